op2_decode: RTL and testbench

Operand-2 decode stage that sits directly upstream of the barrel shifter. It accepts a data-processing instruction with its Rm register value and produces the shifter's input operand, opcode and 5-bit shift amount as a registered valid/ready output. It covers the immediate-rotate, immediate-shift and register-shift forms. Register-specified shifts take one extra cycle to read Rs. Out-of-range and encoded-zero shift amounts are resolved here, so the shifter only ever sees amounts in 0..31.

---
 rtl/shifter_pkg.sv | 13 +
 rtl/op2_amount_resolve.sv | 44 ++++
 rtl/op2_decode.sv | 102 ++++++++++
 tb/tb_op2_decode.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// shifter_pkg: shifter opcode encoding, ARM shift types and operand-decode FSM states
package shifter_pkg;
   typedef logic [2:0] sh_op_t;
   localparam sh_op_t SH_LSL = 3'b000;
   localparam sh_op_t SH_LSR = 3'b001;
   localparam sh_op_t SH_ROR = 3'b010;
   localparam sh_op_t SH_ASR = 3'b011;
   localparam logic [1:0] TY_LSL = 2'b00;
   localparam logic [1:0] TY_LSR = 2'b01;
   localparam logic [1:0] TY_ASR = 2'b10;
   localparam logic [1:0] TY_ROR = 2'b11;
   typedef enum logic [1:0] {IDLE, RS_WAIT, OUT} state_t;
endpackage

// File: rtl/op2_amount_resolve.sv
// op2_amount_resolve: folds ARM zero/out-of-range shift amounts into a shifter op with amount 0..31
module op2_amount_resolve
   import shifter_pkg::*;
(
   input  logic [1:0]  ty_i,
   input  logic [7:0]  amt_i,
   input  logic        reg_form_i,
   input  logic [31:0] rm_i,
   output logic [31:0] sh_a_o,
   output sh_op_t      opcode_o,
   output logic [4:0]  shift_o,
   output logic        rrx_o
);
   logic big, lo_zero;
   assign big = |amt_i[7:5];
   assign lo_zero = amt_i[4:0] == 5'd0;
   always_comb begin
      sh_a_o = rm_i;
      opcode_o = SH_LSL;
      shift_o = amt_i[4:0];
      rrx_o = 1'b0;
      // A register amount of zero leaves the operand untouched whatever the type
      if (!(reg_form_i && amt_i == 8'd0)) begin
         case (ty_i)
            TY_LSL: if (big) begin
               sh_a_o = '0;
               shift_o = '0;
            end
            TY_LSR: if (big || lo_zero) begin
               sh_a_o = '0;
               shift_o = '0;
            end else opcode_o = SH_LSR;
            TY_ASR: begin
               opcode_o = SH_ASR;
               shift_o = (big || lo_zero) ? 5'd31 : amt_i[4:0];
            end
            TY_ROR: begin
               opcode_o = (lo_zero && reg_form_i) ? SH_LSL : SH_ROR;
               rrx_o = lo_zero && !reg_form_i;
            end
         endcase
      end
   end
endmodule

// File: rtl/op2_decode.sv
// op2_decode: operand-2 decode feeding the barrel shifter; register shifts spend one cycle reading Rs
module op2_decode
   import shifter_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rm_data,
   output logic [3:0]  rs_addr,
   input  logic [31:0] rs_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] sh_a,
   output logic [2:0]  sh_opcode,
   output logic [4:0]  sh_shift,
   output logic        rrx
);
   state_t state_q, state_d;
   logic [3:0] rs_addr_q, rs_addr_d;
   logic [1:0] ty_q, ty_d;
   logic [31:0] rm_q, rm_d, sh_a_q, sh_a_d, res_a;
   sh_op_t op_q, op_d, res_op;
   logic [4:0] shift_q, shift_d, res_shift;
   logic rrx_q, rrx_d, res_rrx, rs_wait, accept, unused_ok;
   assign unused_ok = ^{instr[31:26], instr[24:12], rs_data[31:8]};
   assign rs_wait = state_q == RS_WAIT;
   assign in_ready = state_q == IDLE || (state_q == OUT && out_ready);
   assign accept = in_valid && in_ready;
   assign out_valid = state_q == OUT;
   assign rs_addr = rs_addr_q;
   assign sh_a = sh_a_q;
   assign sh_opcode = op_q;
   assign sh_shift = shift_q;
   assign rrx = rrx_q;
   // One resolver serves both the immediate-shift accept path and the Rs read cycle
   op2_amount_resolve u_resolve (
      .ty_i       (rs_wait ? ty_q : instr[6:5]),
      .amt_i      (rs_wait ? rs_data[7:0] : {3'b000, instr[11:7]}),
      .reg_form_i (rs_wait),
      .rm_i       (rs_wait ? rm_q : rm_data),
      .sh_a_o     (res_a),
      .opcode_o   (res_op),
      .shift_o    (res_shift),
      .rrx_o      (res_rrx)
   );
   always_comb begin
      state_d = state_q;
      rs_addr_d = rs_addr_q;
      ty_d = ty_q;
      rm_d = rm_q;
      sh_a_d = sh_a_q;
      op_d = op_q;
      shift_d = shift_q;
      rrx_d = rrx_q;
      if (accept) begin
         rs_addr_d = instr[11:8];
         ty_d = instr[6:5];
         rm_d = rm_data;
         state_d = (!instr[25] && instr[4]) ? RS_WAIT : OUT;
         if (instr[25]) begin
            sh_a_d = {24'h0, instr[7:0]};
            op_d = SH_ROR;
            shift_d = {instr[11:8], 1'b0};
            rrx_d = 1'b0;
         end else if (!instr[4]) begin
            sh_a_d = res_a;
            op_d = res_op;
            shift_d = res_shift;
            rrx_d = res_rrx;
         end
      end else if (rs_wait) begin
         state_d = OUT;
         sh_a_d = res_a;
         op_d = res_op;
         shift_d = res_shift;
         rrx_d = res_rrx;
      end else if (state_q == OUT && out_ready) state_d = IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rs_addr_q <= '0;
         ty_q <= '0;
         rm_q <= '0;
         sh_a_q <= '0;
         op_q <= SH_LSL;
         shift_q <= '0;
         rrx_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rs_addr_q <= rs_addr_d;
         ty_q <= ty_d;
         rm_q <= rm_d;
         sh_a_q <= sh_a_d;
         op_q <= op_d;
         shift_q <= shift_d;
         rrx_q <= rrx_d;
      end
   end
endmodule

// File: tb/tb_op2_decode.sv
// tb_op2_decode: scoreboard bench for op2_decode using an independent operand-2 reference model
module tb_op2_decode;
   typedef struct packed {
      logic [31:0] a;
      logic [2:0]  op;
      logic [4:0]  sh;
      logic        rrx;
   } exp_t;
   logic clk = 1'b0, reset, in_valid, in_ready, out_valid, out_ready, rrx;
   logic [31:0] instr, rm_data, rs_data, sh_a;
   logic [3:0] rs_addr;
   logic [2:0] sh_opcode;
   logic [4:0] sh_shift;
   logic [31:0] rf [16];
   exp_t exp_q[$];
   int n_checks = 0, n_err = 0, hs_cnt = 0, run_len = 0, best_run = 0;
   logic [31:0] ins_tab [8], rm_tab [8];
   logic [31:0] rv_tab [7], rrm_tab [7];
   logic [1:0] rty_tab [7];
   always #5 clk = ~clk;
   assign rs_data = rf[rs_addr];
   op2_decode dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rm_data(rm_data), .rs_addr(rs_addr), .rs_data(rs_data),
      .out_valid(out_valid), .out_ready(out_ready), .sh_a(sh_a),
      .sh_opcode(sh_opcode), .sh_shift(sh_shift), .rrx(rrx)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rm, input logic [31:0] rs);
      logic [4:0] n;
      logic [7:0] n8;
      if (ins[25]) return '{{24'h0, ins[7:0]}, 3'b010, {ins[11:8], 1'b0}, 1'b0};
      n = ins[11:7];
      n8 = rs[7:0];
      if (!ins[4]) begin
         case (ins[6:5])
            2'b00: return '{rm, 3'b000, n, 1'b0};
            2'b01: return (n == 0) ? '{32'h0, 3'b000, 5'd0, 1'b0} : '{rm, 3'b001, n, 1'b0};
            2'b10: return (n == 0) ? '{rm, 3'b011, 5'd31, 1'b0} : '{rm, 3'b011, n, 1'b0};
            default: return (n == 0) ? '{rm, 3'b010, 5'd0, 1'b1} : '{rm, 3'b010, n, 1'b0};
         endcase
      end
      if (n8 == 0) return '{rm, 3'b000, 5'd0, 1'b0};
      case (ins[6:5])
         2'b00: return (n8 >= 32) ? '{32'h0, 3'b000, 5'd0, 1'b0} : '{rm, 3'b000, n8[4:0], 1'b0};
         2'b01: return (n8 >= 32) ? '{32'h0, 3'b000, 5'd0, 1'b0} : '{rm, 3'b001, n8[4:0], 1'b0};
         2'b10: return (n8 >= 32) ? '{rm, 3'b011, 5'd31, 1'b0} : '{rm, 3'b011, n8[4:0], 1'b0};
         default: return (n8[4:0] == 0) ? '{rm, 3'b000, 5'd0, 1'b0} : '{rm, 3'b010, n8[4:0], 1'b0};
      endcase
   endfunction
   function automatic logic [31:0] imm_rot(input logic [3:0] rot, input logic [7:0] imm);
      return 32'h0200_0000 | {20'h0, rot, imm};
   endfunction
   function automatic logic [31:0] imm_sh(input logic [4:0] amt, input logic [1:0] ty);
      return {20'h0, amt, ty, 1'b0, 4'h2};
   endfunction
   function automatic logic [31:0] reg_sh(input logic [3:0] rs, input logic [1:0] ty);
      return {20'h0, rs, 1'b0, ty, 1'b1, 4'h2};
   endfunction
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         exp_t e;
         hs_cnt++;
         run_len++;
         if (run_len > best_run) best_run = run_len;
         if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
         else begin
            e = exp_q.pop_front();
            check("sh_a", sh_a, e.a);
            check("sh_opcode", {29'h0, sh_opcode}, {29'h0, e.op});
            check("sh_shift", {27'h0, sh_shift}, {27'h0, e.sh});
            check("rrx", {31'h0, rrx}, {31'h0, e.rrx});
         end
      end else run_len = 0;
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [31:0] ins, input logic [31:0] rm);
      bit done = 0;
      in_valid = 1'b1;
      instr = ins;
      rm_data = rm;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(model(ins, rm, rf[ins[11:8]]));
            done = 1;
         end
      end
      if (!done) check("accept_timeout", 32'd0, 32'd1);
      step();
      in_valid = 1'b0;
   endtask
   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
      check("drain", exp_q.size(), 32'd0);
   endtask
   initial begin
      int hs0;
      in_valid = 0;
      instr = 0;
      rm_data = 0;
      out_ready = 1;
      reset = 1;
      for (int i = 0; i < 16; i++) rf[i] = 32'h0;
      ins_tab = '{imm_sh(0, 2'b01), imm_sh(0, 2'b10), imm_sh(0, 2'b11), imm_sh(0, 2'b00),
                  imm_sh(7, 2'b01), imm_sh(31, 2'b10), imm_sh(9, 2'b11), imm_rot(4'h0, 8'h5A)};
      rm_tab = '{32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'h5,
                 32'hFFFF_0000, 32'hF000_0001, 32'hCAFE_F00D, 32'h7};
      rv_tab = '{32'h0, 32'd40, 32'd32, 32'd36, 32'd8, 32'd32, 32'h104};
      rty_tab = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00};
      rrm_tab = '{32'hABCD_0001, 32'h8000_0000, 32'h1111_2222, 32'h3333_4444,
                  32'hFF00_FF00, 32'h5555_AAAA, 32'h0000_0003};
      step();
      check("rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("rst_sh_a", sh_a, 32'h0);
      check("rst_opcode", {29'h0, sh_opcode}, 32'h0);
      check("rst_shift", {27'h0, sh_shift}, 32'h0);
      check("rst_rrx", {31'h0, rrx}, 32'h0);
      check("rst_rs_addr", {28'h0, rs_addr}, 32'h0);
      reset = 0;
      @(negedge clk);
      check("rst_in_ready", {31'h0, in_ready}, 32'h1);
      step();
      send(imm_rot(4'hF, 8'hFF), 32'h0);
      @(negedge clk);
      check("imm_rot_lat", {31'h0, out_valid}, 32'h1);
      step();
      for (int i = 0; i < 8; i++) begin
         send(ins_tab[i], rm_tab[i]);
         @(negedge clk);
         check("imm_lat", {31'h0, out_valid}, 32'h1);
         step();
      end
      rf[3] = 32'h21;
      send(reg_sh(4'd3, 2'b00), 32'h1);
      @(negedge clk);
      check("rs_addr", {28'h0, rs_addr}, 32'd3);
      check("reg_lat1", {31'h0, out_valid}, 32'h0);
      @(negedge clk);
      check("reg_lat2", {31'h0, out_valid}, 32'h1);
      step();
      rf[3] = 32'h5;
      send(reg_sh(4'd3, 2'b00), 32'h1);
      @(negedge clk);
      @(negedge clk);
      check("reg_lat2", {31'h0, out_valid}, 32'h1);
      step();
      for (int i = 0; i < 7; i++) begin
         rf[7] = rv_tab[i];
         send(reg_sh(4'd7, rty_tab[i]), rrm_tab[i]);
         @(negedge clk);
         @(negedge clk);
         check("reg_lat2", {31'h0, out_valid}, 32'h1);
         step();
      end
      drain();
      out_ready = 0;
      send(imm_sh(5'd3, 2'b00), 32'h0F0F_0F0F);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_valid", {31'h0, out_valid}, 32'h1);
         check("bp_in_ready", {31'h0, in_ready}, 32'h0);
         check("bp_sh_a", sh_a, exp_q[0].a);
         check("bp_shift", {27'h0, sh_shift}, {27'h0, exp_q[0].sh});
      end
      step();
      out_ready = 1;
      send(imm_rot(4'h1, 8'h81), 32'h0);
      @(negedge clk);
      check("bp_next_valid", {31'h0, out_valid}, 32'h1);
      step();
      drain();
      repeat (2) step();
      best_run = 0;
      send(imm_sh(5'd1, 2'b00), 32'h1);
      send(imm_sh(5'd2, 2'b01), 32'h8000_0000);
      send(imm_rot(4'h2, 8'h3C), 32'h0);
      send(imm_sh(5'd4, 2'b10), 32'hF000_0000);
      repeat (3) step();
      check("b2b_run", best_run, 32'd4);
      drain();
      rf[2] = 32'h4;
      send(reg_sh(4'd2, 2'b10), 32'hDEAD_BEEF);
      reset = 1;
      exp_q.delete();
      step();
      check("rstw_out_valid", {31'h0, out_valid}, 32'h0);
      check("rstw_sh_a", sh_a, 32'h0);
      check("rstw_opcode", {29'h0, sh_opcode}, 32'h0);
      check("rstw_shift", {27'h0, sh_shift}, 32'h0);
      check("rstw_rrx", {31'h0, rrx}, 32'h0);
      check("rstw_rs_addr", {28'h0, rs_addr}, 32'h0);
      reset = 0;
      hs0 = hs_cnt;
      @(negedge clk);
      check("rstw_in_ready", {31'h0, in_ready}, 32'h1);
      repeat (4) step();
      check("rstw_no_out", hs_cnt, hs0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
